accum_burst_scheduler: RTL and testbench



---
 rtl/accum_pkg.sv | 15 +
 rtl/sat_accum_core.sv | 47 ++++
 rtl/accum_burst_scheduler.sv | 133 +++++++++++++
 tb/tb_accum_burst_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared types and constants for the burst accumulator scheduler.
package accum_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        RESULT = 2'd2
    } state_e;

    localparam int SUM_W    = 16;
    localparam int SAMPLE_W = 8;

    localparam logic [SUM_W-1:0] SAT_VAL = 16'hFFFF;

endpackage

// File: rtl/sat_accum_core.sv
// 16-bit accumulator that clamps at SAT_VAL on carry-out and keeps a sticky
// per-burst saturation flag.
module sat_accum_core
    import accum_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clear_i,
    input  logic                add_en_i,
    input  logic [SAMPLE_W-1:0] data_i,
    output logic [SUM_W-1:0]    sum_o,
    output logic                sat_o
);

    logic [SUM_W-1:0] sum_q, sum_d;
    logic             sat_q, sat_d;
    logic [SUM_W:0]   ext_sum;

    assign ext_sum = {1'b0, sum_q} + {{(SUM_W + 1 - SAMPLE_W){1'b0}}, data_i};

    always_comb begin
        sum_d = sum_q;
        sat_d = sat_q;
        if (clear_i) begin
            sum_d = '0;
            sat_d = 1'b0;
        end else if (add_en_i) begin
            // Carry out of the 17-bit add means the true sum no longer fits.
            sum_d = ext_sum[SUM_W] ? SAT_VAL : ext_sum[SUM_W-1:0];
            sat_d = sat_q | ext_sum[SUM_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
            sat_q <= 1'b0;
        end else begin
            sum_q <= sum_d;
            sat_q <= sat_d;
        end
    end

    assign sum_o = sum_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/accum_burst_scheduler.sv
// Round-robin scheduler sharing one saturating accumulator among NREQ
// streaming requesters; emits one {sum, id, count, status} result per burst.
module accum_burst_scheduler
    import accum_pkg::*;
#(
    parameter int  NREQ    = 4,
    parameter int  MAX_LEN = 255,
    localparam int IDW     = $clog2(NREQ),
    localparam int CW      = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*SAMPLE_W-1:0] req_data,
    input  logic [NREQ-1:0]          req_last,
    output logic [NREQ-1:0]          req_ready,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [SUM_W-1:0]         res_sum,
    output logic [IDW-1:0]           res_id,
    output logic [CW-1:0]            res_count,
    output logic                     res_sat,
    output logic                     res_trunc,
    output logic                     busy
);

    state_e         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [CW-1:0]  count_q, count_d;
    logic           trunc_q, trunc_d;

    logic                any_valid;
    logic                xfer;
    logic                at_max;
    logic                acc_clear;
    logic                acc_add;
    logic [SAMPLE_W-1:0] grant_data;

    // First valid requester at or after ptr, wrapping; scanning downward lets
    // the closest candidate overwrite the others.
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] v,
                                               input logic [IDW-1:0]  ptr);
        logic [IDW-1:0] win;
        int             idx;
        win = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (v[idx]) win = IDW'(idx);
        end
        return win;
    endfunction

    assign any_valid  = |req_valid;
    assign xfer       = (state_q == ACCUM) && req_valid[grant_q];
    assign at_max     = (count_q == CW'(MAX_LEN - 1));
    assign grant_data = req_data[SAMPLE_W*grant_q +: SAMPLE_W];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        count_d   = count_q;
        trunc_d   = trunc_q;
        acc_clear = 1'b0;
        acc_add   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_d   = rr_pick(req_valid, rr_q);
                    count_d   = '0;
                    trunc_d   = 1'b0;
                    acc_clear = 1'b1;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                if (xfer) begin
                    acc_add = 1'b1;
                    count_d = count_q + 1'b1;
                    if (req_last[grant_q]) begin
                        state_d = RESULT;
                    end else if (at_max) begin
                        trunc_d = 1'b1;
                        state_d = RESULT;
                    end
                end
            end
            RESULT: begin
                if (res_ready) begin
                    rr_d    = (grant_q == IDW'(NREQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            count_q <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            count_q <= count_d;
            trunc_q <= trunc_d;
        end
    end

    sat_accum_core u_core (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (acc_clear),
        .add_en_i (acc_add),
        .data_i   (grant_data),
        .sum_o    (res_sum),
        .sat_o    (res_sat)
    );

    // Everything below decodes registered state only.
    assign req_ready = (state_q == ACCUM) ? (NREQ'(1) << grant_q) : '0;
    assign res_valid = (state_q == RESULT);
    assign busy      = (state_q != IDLE);
    assign res_id    = grant_q;
    assign res_count = count_q;
    assign res_trunc = trunc_q;

endmodule

// File: tb/tb_accum_burst_scheduler.sv
// Directed bench for accum_burst_scheduler: table of bursts plus hand-written
// arbitration, backpressure, stall, reset and saturation sequences.
module tb_accum_burst_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic        res_valid, res_ready, res_sat, res_trunc, busy;
    logic [15:0] res_sum;
    logic [1:0]  res_id;
    logic [7:0]  res_count;

    logic [3:0]  b_valid, b_last, b_ready;
    logic [31:0] b_data;
    logic        b_res_valid, b_res_ready, b_sat, b_trunc, b_busy;
    logic [15:0] b_sum;
    logic [1:0]  b_id;
    logic [8:0]  b_count;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    accum_burst_scheduler #(.NREQ(4), .MAX_LEN(255)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_id(res_id), .res_count(res_count), .res_sat(res_sat),
        .res_trunc(res_trunc), .busy(busy)
    );

    accum_burst_scheduler #(.NREQ(4), .MAX_LEN(300)) dut_long (
        .clk(clk), .rst(rst),
        .req_valid(b_valid), .req_data(b_data), .req_last(b_last),
        .req_ready(b_ready),
        .res_valid(b_res_valid), .res_ready(b_res_ready), .res_sum(b_sum),
        .res_id(b_id), .res_count(b_count), .res_sat(b_sat),
        .res_trunc(b_trunc), .busy(b_busy)
    );

    typedef struct {
        int         id;
        int         len;
        logic [7:0] d0;
        logic [7:0] step;
        int         exp_sum;
    } vec_t;

    vec_t tv[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Streams len beats d0, d0+step, ... from requester id, honouring req_ready.
    task automatic drive_burst(input int id, input int len, input logic [7:0] d0,
                               input logic [7:0] step, input bit use_last,
                               output int cycles);
        int         k;
        bit         fire;
        logic [7:0] d;
        k      = 0;
        cycles = 0;
        d      = d0;
        req_valid[id]       = 1'b1;
        req_data[id*8 +: 8] = d;
        req_last[id]        = use_last && (len == 1);
        while (k < len && cycles < 2000) begin
            fire = req_ready[id];
            tick();
            cycles++;
            if (fire) begin
                k++;
                d = d + step;
                req_data[id*8 +: 8] = d;
                req_last[id]        = use_last && (k == len - 1);
            end
        end
        req_valid[id] = 1'b0;
        req_last[id]  = 1'b0;
        if (k < len) chk("burst_timeout", k, len);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        int  guard;
        int  k;
        bit  fire;

        tv[0] = '{2, 3, 8'd10,  8'd10, 60};
        tv[1] = '{1, 1, 8'd200, 8'd0,  200};
        tv[2] = '{3, 4, 8'd255, 8'd0,  1020};
        tv[3] = '{0, 5, 8'd1,   8'd1,  15};
        tv[4] = '{2, 2, 8'd0,   8'd0,  0};

        rst = 1'b1;
        req_valid = '0; req_last = '0; req_data = '0; res_ready = 1'b1;
        b_valid = '0; b_last = '0; b_data = '0; b_res_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_res_valid", res_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", res_sum, 0);
        chk("rst_id", res_id, 0);
        chk("rst_count", res_count, 0);
        chk("rst_sat", res_sat, 0);
        chk("rst_trunc", res_trunc, 0);
        chk("rst_b_valid", b_res_valid, 0);

        for (int i = 0; i < 5; i++) begin
            drive_burst(tv[i].id, tv[i].len, tv[i].d0, tv[i].step, 1'b1, cyc);
            chk("tbl_latency", cyc, tv[i].len + 1);
            chk("tbl_res_valid", res_valid, 1);
            chk("tbl_sum", res_sum, tv[i].exp_sum);
            chk("tbl_id", res_id, tv[i].id);
            chk("tbl_count", res_count, tv[i].len);
            chk("tbl_sat", res_sat, 0);
            chk("tbl_trunc", res_trunc, 0);
            chk("tbl_req_ready", req_ready, 0);
            tick();
            chk("tbl_valid_1cyc", res_valid, 0);
        end

        // Round-robin with every requester continuously valid.
        pulse_reset();
        req_data  = {8'd4, 8'd3, 8'd2, 8'd1};
        req_last  = 4'hF;
        req_valid = 4'hF;
        for (int r = 0; r < 5; r++) begin
            guard = 0;
            while (!res_valid && guard < 10) begin
                tick();
                guard++;
            end
            chk("rr_res_valid", res_valid, 1);
            chk("rr_id", res_id, r % 4);
            chk("rr_sum", res_sum, (r % 4) + 1);
            if (r == 4) begin
                req_valid = '0;
                req_last  = '0;
            end
            tick();
        end

        // Result backpressure with a competing requester waiting.
        pulse_reset();
        res_ready = 1'b0;
        req_valid[3] = 1'b1; req_data[31:24] = 8'd9; req_last[3] = 1'b1;
        drive_burst(1, 2, 8'd5, 8'd1, 1'b1, cyc);
        for (int j = 0; j < 5; j++) begin
            chk("bp_res_valid", res_valid, 1);
            chk("bp_sum", res_sum, 11);
            chk("bp_id", res_id, 1);
            chk("bp_count", res_count, 2);
            chk("bp_req_ready", req_ready, 0);
            tick();
        end
        res_ready = 1'b1;
        chk("bp_hold_valid", res_valid, 1);
        tick();
        chk("bp_accepted", res_valid, 0);
        chk("bp_idle_ready", req_ready, 0);
        tick();
        chk("bp_grant3", req_ready, 4'b1000);
        tick();
        chk("bp_r3_valid", res_valid, 1);
        chk("bp_r3_id", res_id, 3);
        chk("bp_r3_sum", res_sum, 9);
        req_valid[3] = 1'b0; req_last[3] = 1'b0;
        tick();

        // Granted requester 1 stalls while requester 3 keeps asking.
        req_valid[1] = 1'b1; req_data[15:8] = 8'd7;
        req_valid[3] = 1'b1; req_data[31:24] = 8'd40; req_last[3] = 1'b1;
        tick();
        chk("stall_grant1", req_ready, 4'b0010);
        tick();
        req_valid[1] = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("stall_ready", req_ready, 4'b0010);
            chk("stall_no_res", res_valid, 0);
            tick();
        end
        req_valid[1] = 1'b1; req_data[15:8] = 8'd8;
        tick();
        req_data[15:8] = 8'd9; req_last[1] = 1'b1;
        tick();
        chk("stall_res_valid", res_valid, 1);
        chk("stall_sum", res_sum, 24);
        chk("stall_id", res_id, 1);
        chk("stall_count", res_count, 3);
        req_valid = '0; req_last = '0;
        tick();

        // Reset in the middle of a burst from requester 2.
        req_valid[2] = 1'b1; req_data[23:16] = 8'd100;
        tick();
        tick();
        tick();
        rst = 1'b1; req_valid = '0;
        tick();
        chk("mid_rst_valid", res_valid, 0);
        chk("mid_rst_ready", req_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_sum", res_sum, 0);
        chk("mid_rst_count", res_count, 0);
        chk("mid_rst_id", res_id, 0);
        rst = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("mid_rst_no_res", res_valid, 0);
        end
        req_valid[3] = 1'b1; req_data[31:24] = 8'd77; req_last[3] = 1'b1;
        drive_burst(1, 1, 8'd50, 8'd0, 1'b1, cyc);
        chk("post_rst_id", res_id, 1);
        chk("post_rst_sum", res_sum, 50);
        chk("post_rst_count", res_count, 1);
        req_valid = '0; req_last = '0;
        tick();

        // MAX_LEN=255 cut: 255 x 255 = 65025 = 16'hFE01, no overflow yet.
        drive_burst(0, 255, 8'd255, 8'd0, 1'b0, cyc);
        chk("trunc_res_valid", res_valid, 1);
        chk("trunc_sum", res_sum, 16'hFE01);
        chk("trunc_count", res_count, 255);
        chk("trunc_flag", res_trunc, 1);
        chk("trunc_sat", res_sat, 0);
        tick();

        // MAX_LEN=300: 257 x 255 = 65535 fits, beat 258 overflows.
        b_valid[0] = 1'b1; b_data[7:0] = 8'd255; b_last[0] = 1'b0;
        k = 0; cyc = 0;
        while (k < 258 && cyc < 1000) begin
            fire = b_ready[0];
            tick();
            cyc++;
            if (fire) begin
                k++;
                b_last[0] = (k == 257);
            end
        end
        b_valid = '0; b_last = '0;
        chk("sat_beats", k, 258);
        chk("sat_res_valid", b_res_valid, 1);
        chk("sat_sum", b_sum, 16'hFFFF);
        chk("sat_flag", b_sat, 1);
        chk("sat_count", b_count, 258);
        chk("sat_trunc", b_trunc, 0);
        chk("sat_id", b_id, 0);
        tick();
        chk("sat_accepted", b_res_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
